// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider: per-channel toggle/pulse output,
// tick strobe, and a valid/ready divisor port applied at the next terminal count.
module multi_channel_clock_divider #(
   parameter int          NUM_CH      = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 50000000,
   localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic [NUM_CH-1:0] mode,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] cfg_sel;
   logic [NUM_CH-1:0] pend_vec;
   logic [CNT_W-1:0]  cfg_div_clamped;

   assign cfg_div_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
   // Out-of-range channel selects nothing, so the write is accepted and dropped.
   assign cfg_ready = ~|(pend_vec & cfg_sel);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] div_act_reg;
         logic [CNT_W-1:0] div_pend_reg;
         logic             pend_reg;
         logic             clk_reg;
         logic             tick_reg;
         logic             tc;
         logic             accept;

         assign cfg_sel[gi] = (cfg_ch == CH_W'(gi));
         assign tc          = (cnt_reg == div_act_reg - CNT_W'(1));
         assign accept      = cfg_valid && cfg_sel[gi] && !pend_reg;

         always_ff @(posedge clk_in) begin
            if (!rst_n) begin
               cnt_reg      <= '0;
               div_act_reg  <= CNT_W'(DEFAULT_DIV);
               div_pend_reg <= '0;
               pend_reg     <= 1'b0;
               clk_reg      <= 1'b0;
               tick_reg     <= 1'b0;
            end else if (!en[gi]) begin
               cnt_reg  <= '0;
               tick_reg <= 1'b0;
               clk_reg  <= 1'b0;
               // While idle, divisor updates land immediately.
               if (pend_reg) begin
                  div_act_reg <= div_pend_reg;
                  pend_reg    <= 1'b0;
               end else if (accept) begin
                  div_act_reg <= cfg_div_clamped;
               end
            end else begin
               if (tc) begin
                  cnt_reg  <= '0;
                  tick_reg <= 1'b1;
                  clk_reg  <= mode[gi] ? 1'b1 : ~clk_reg;
                  if (pend_reg) begin
                     div_act_reg <= div_pend_reg;
                     pend_reg    <= 1'b0;
                  end
               end else begin
                  cnt_reg  <= cnt_reg + CNT_W'(1);
                  tick_reg <= 1'b0;
                  if (mode[gi]) clk_reg <= 1'b0;
               end
               // A write on the TC edge leaves the current period on the old divisor.
               if (accept) begin
                  div_pend_reg <= cfg_div_clamped;
                  pend_reg     <= 1'b1;
               end
            end
         end

         assign pend_vec[gi] = pend_reg;
         assign clk_out[gi]  = clk_reg;
         assign tick[gi]     = tick_reg;
      end
   endgenerate

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider (NUM_CH=4, DEFAULT_DIV=5).
module tb_multi_channel_clock_divider;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   int n_checks = 0;
   int n_errors = 0;

   multi_channel_clock_divider #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(5)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .mode(mode),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a write for one edge, then drop cfg_valid.
   task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] dv);
      cfg_ch    = ch;
      cfg_div   = dv;
      cfg_valid = 1'b1;
      $display("cfg write ch=%0d div=%0d ready=%0b", ch, dv, cfg_ready);
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = '0; mode = '0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      step();
      chk("reset_clk_out", 32'(clk_out), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      chk("reset_ready", 32'(cfg_ready), 32'h1);

      // Ch0 with default divisor 5, toggle mode.
      rst_n = 1'b1; en = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("ch0_tick", 32'(tick), (k % 5 == 0) ? 32'h1 : 32'h0);
         chk("ch0_clk", 32'(clk_out), ((k / 5) % 2 == 1) ? 32'h1 : 32'h0);
      end
      en = 4'b0000;
      step();
      chk("ch0_off", 32'(clk_out), 32'h0);

      // Ch1: div 4, write 7 at cnt=2.
      cfg_write(2'd1, 16'd4);
      chk("ch1_ready_idle", 32'(cfg_ready), 32'h1);
      en = 4'b0010;
      step(); step();
      chk("ch1_ready_pre", 32'(cfg_ready), 32'h1);
      cfg_write(2'd1, 16'd7);
      chk("ch1_ready_busy", 32'(cfg_ready), 32'h0);
      chk("ch1_no_tick_e3", 32'(tick[1]), 32'h0);
      step();
      chk("ch1_tick_e4", 32'(tick[1]), 32'h1);
      chk("ch1_ready_back", 32'(cfg_ready), 32'h1);
      for (int k = 5; k <= 18; k++) begin
         step();
         chk("ch1_tick", 32'(tick[1]), (k == 11 || k == 18) ? 32'h1 : 32'h0);
         chk("ch1_clk", 32'(clk_out[1]), (k < 11 || k == 18) ? 32'h1 : 32'h0);
      end
      en = 4'b0000;
      step();

      // Ch2: div 3, write 6 on the exact TC edge.
      cfg_write(2'd2, 16'd3);
      en = 4'b0100;
      step(); step();
      cfg_write(2'd2, 16'd6);
      chk("ch2_tick_e3", 32'(tick[2]), 32'h1);
      chk("ch2_ready_busy", 32'(cfg_ready), 32'h0);
      for (int k = 4; k <= 18; k++) begin
         step();
         chk("ch2_tick", 32'(tick[2]), (k == 6 || k == 12 || k == 18) ? 32'h1 : 32'h0);
         if (k == 6) chk("ch2_ready_back", 32'(cfg_ready), 32'h1);
      end
      en = 4'b0000;
      step();

      // Ch3: divisor 0 clamps to 1, pulse mode stays high.
      cfg_write(2'd3, 16'd0);
      en = 4'b1000; mode = 4'b1000;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("ch3_tick", 32'(tick[3]), 32'h1);
         chk("ch3_clk", 32'(clk_out[3]), 32'h1);
      end
      en = 4'b0000; mode = 4'b0000;
      step();

      // Ch0: disable with a pending divisor of 8, then re-enable.
      en = 4'b0001;
      step(); step();
      cfg_write(2'd0, 16'd8);
      en = 4'b0000;
      step();
      chk("ch0_off_tick", 32'(tick), 32'h0);
      chk("ch0_off_clk", 32'(clk_out), 32'h0);
      chk("ch0_off_ready", 32'(cfg_ready), 32'h1);
      step();
      chk("ch0_off2_clk", 32'(clk_out), 32'h0);
      en = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("ch0_reen_tick", 32'(tick[0]), (k == 8) ? 32'h1 : 32'h0);
         chk("ch0_reen_clk", 32'(clk_out[0]), (k == 8) ? 32'h1 : 32'h0);
      end
      en = 4'b0000;
      step();

      // Reset mid-count with a pending write on ch1.
      en = 4'b0110;
      step(); step();
      cfg_write(2'd1, 16'd3);
      chk("rst_ready_busy", 32'(cfg_ready), 32'h0);
      rst_n = 1'b0;
      step();
      chk("rst_mid_clk", 32'(clk_out), 32'h0);
      chk("rst_mid_tick", 32'(tick), 32'h0);
      chk("rst_mid_ready", 32'(cfg_ready), 32'h1);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("rst_resume_tick", 32'(tick), (k == 5 || k == 10) ? 32'h6 : 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_channel_clock_divider.md
# multi_channel_clock_divider

Parametrised, multi-channel successor to the single fixed-ratio clock divider. It generates NUM_CH independent divided outputs from one system clock. Each channel has a runtime-programmable divisor, a per-channel mode (50% toggle clock or single-cycle pulse), a per-channel enable and a registered tick strobe. Divisor changes pass through a valid/ready config port and take effect glitch-free at the channel's next terminal count. The block feeds the traffic-light phase timers and the display/blink logic.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 32: counter and divisor width.
- DEFAULT_DIV, 50000000: divisor loaded into every channel at reset. Must be 1..2^CNT_W-1.
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  NUM_CH  per-channel run enable.
- mode  in  NUM_CH  per-channel output mode: 0 = toggle (square wave), 1 = pulse.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write can be accepted; combinational, equals ~pend[cfg_ch], or 1 if cfg_ch >= NUM_CH.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new divisor; 0 is clamped to 1.
- clk_out  out  NUM_CH  divided output per channel, registered.
- tick  out  NUM_CH  one-cycle strobe at each terminal count, registered.

## Operation
- Per-channel state: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend flag, clk_out, tick.
- Reset (rst_n=0 at an edge): cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend=0, clk_out=0, tick=0 for all channels. Any pending write is discarded. Reset mid-count aborts the count immediately.
- Running (en[i]=1):
  - Terminal count (TC) when cnt==div_act-1.
  - On TC: cnt<=0, tick<=1. Mode 0: clk_out<=~clk_out. Mode 1: clk_out<=1.
  - Otherwise: cnt<=cnt+1, tick<=0. Mode 1: clk_out<=0. Mode 0: clk_out holds.
- Disabled (en[i]=0): cnt<=0, tick<=0, clk_out<=0 on the next edge. Re-enable restarts a full period from 0.
- Config handshake:
  - A write is accepted on an edge where cfg_valid & cfg_ready.
  - Channel enabled: div_pend<=max(cfg_div,1), pend<=1.
  - Channel disabled: div_act<=max(cfg_div,1) directly; pend stays 0.
  - Pending value: on the channel's next TC, div_act<=div_pend, pend<=0. The new divisor governs the count starting at cnt=0.
  - Channel disabled while pend=1: div_act<=div_pend, pend<=0 on that edge.
  - cfg_ch >= NUM_CH: accepted and ignored.
- Mode change takes effect at the next edge. Switching 0->1 mid-period: clk_out follows pulse rules from that edge.
- Arithmetic: cnt+1 never overflows because cnt <= div_act-1 <= 2^CNT_W-2. Compare uses full CNT_W width.

## Timing
- With en high from edge E1 (first edge sampling en=1), the first tick is high in the cycle after edge E(div_act). After that, tick is high 1 cycle in every div_act cycles.
- Mode 0 clk_out period = 2*div_act cycles, 50% duty. Mode 1 clk_out is identical to tick.
- div_act=1: tick is continuously high. Mode 0 clk_out toggles every cycle (clk_in/2).
- Config write accepted on the same edge as that channel's TC: the current TC uses the old div_act and sets pend. The new value applies at the following TC.
- cfg_ready has zero-cycle latency. It deasserts the cycle after acceptance until the applying TC edge, and is high again in the cycle after that edge.
- Channels are fully independent; simultaneous TCs on multiple channels are legal.

## Test plan
- Reset release, NUM_CH=4, DEFAULT_DIV=5, en=4'b0001, mode=0 -> tick[0] high in cycles 5,10,15…; clk_out[0] period 10; other outputs stay 0.
- Channel 1 running div=4 at cnt=2, write cfg_div=7 -> cfg_ready=0 for ch1; next tick after 2 more cycles (old divisor); then ticks every 7 cycles; cfg_ready back to 1.
- Write on the exact TC edge of ch2 (div 3 -> 6) -> one more period of 3, then periods of 6.
- cfg_div=0 to disabled ch3, then enable with mode=1 -> tick and clk_out[3] continuously high from the first enabled edge.
- en[0] dropped mid-period with pend=1 (div_pend=8), re-enabled -> outputs 0 while off; first tick 8 cycles after re-enable.
- rst_n low for 1 cycle mid-count with pending writes -> all outputs 0 next cycle; counting resumes with DEFAULT_DIV; pending value lost.
